instruction_loader: RTL and testbench

- Byte-serial program loader that writes the CPU instruction memory, the write-side counterpart of the CPU's instruction fetch port.
- Accepts a framed byte stream from the chip pins through a valid/ready handshake. The frame is a header (word count), little-endian 32-bit instruction words and an XOR checksum.
- Emits single-cycle word writes to the instruction memory.
- Holds the CPU in reset (cpu_hold) until a complete, checksum-valid program has been loaded.

---
 rtl/instruction_loader.sv | 142 ++++++++++++++
 tb/tb_instruction_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// Byte-serial loader for the CPU instruction memory.
// It takes a framed stream over a valid/ready handshake. The frame is a count byte, then
// little-endian 32-bit words, then an XOR checksum byte. Each assembled word is written to
// memory with a one-cycle strobe. The CPU is held in reset until a frame with a good
// checksum has been fully loaded.
module instruction_loader #(
  parameter int unsigned NUM_WORDS     = 16,
  parameter int unsigned ADDRESS_WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic                     write_enable,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [31:0]              write_data,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     error
);

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StData,
    StWrite,
    StCheck,
    StRun,
    StError
  } state_e;

  localparam logic [7:0] MaxCount = 8'(NUM_WORDS);

  state_e                   state_q, state_d;
  logic [7:0]               count_q, count_d;
  logic [7:0]               checksum_q, checksum_d;
  logic [1:0]               idx_q, idx_d;
  logic [ADDRESS_WIDTH-1:0] word_q, word_d;
  logic [31:0]              data_q, data_d;

  logic xfer;
  logic last_word;
  logic start_ok;

  assign xfer      = byte_valid && byte_ready;
  // True in WRITE when this word is the last one of the frame. The word index is then held,
  // so it never reaches count and the address never wraps.
  assign last_word = (8'(word_q) + 8'd1) == count_q;
  assign start_ok  = start && (state_q == StIdle || state_q == StRun || state_q == StError);

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= 8'd0;
      checksum_q <= 8'd0;
      idx_q      <= 2'd0;
      word_q     <= '0;
      data_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      checksum_q <= checksum_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      data_q     <= data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StRun, StError: begin
        if (start) state_d = StHeader;
      end
      StHeader: begin
        if (xfer) begin
          if (byte_in == 8'd0 || byte_in > MaxCount) state_d = StError;
          else                                       state_d = StData;
        end
      end
      StData: begin
        if (xfer && idx_q == 2'd3) state_d = StWrite;
      end
      StWrite: begin
        state_d = last_word ? StCheck : StData;
      end
      StCheck: begin
        if (xfer) state_d = (byte_in == checksum_q) ? StRun : StError;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values: header capture, byte assembly, checksum and word index
  always_comb begin
    count_d    = count_q;
    checksum_d = checksum_q;
    idx_d      = idx_q;
    word_d     = word_q;
    data_d     = data_q;
    if (start_ok) begin
      checksum_d = 8'd0;
      idx_d      = 2'd0;
      word_d     = '0;
    end
    case (state_q)
      StHeader: begin
        if (xfer) begin
          count_d    = byte_in;
          checksum_d = byte_in;
        end
      end
      StData: begin
        if (xfer) begin
          data_d[{idx_q, 3'b000} +: 8] = byte_in;
          checksum_d                   = checksum_q ^ byte_in;
          idx_d                        = idx_q + 2'd1;
        end
      end
      StWrite: begin
        if (!last_word) word_d = word_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    byte_ready    = (state_q == StHeader) || (state_q == StData) || (state_q == StCheck);
    write_enable  = (state_q == StWrite);
    write_address = word_q;
    write_data    = data_q;
    cpu_hold      = (state_q != StRun);
    done          = (state_q == StRun);
    error         = (state_q == StError);
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: a table of whole frames plus hand-written
// sequences for restarts, aborts and the full-depth frame.
module tb_instruction_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        write_enable;
  logic [3:0]  write_address;
  logic [31:0] write_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;
  int stall = 0;

  instruction_loader #(
    .NUM_WORDS    (16),
    .ADDRESS_WIDTH(4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .write_enable (write_enable),
    .write_address(write_address),
    .write_data   (write_data),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error)
  );

  always #5 clock = ~clock;

  // Memory image as seen on the write port, plus strobe-shape violations
  logic [31:0] seen_mem [16];
  int          wr_count    = 0;
  int          strobe_viol = 0;
  logic        we_prev     = 1'b0;

  always @(negedge clock) begin
    if (write_enable) begin
      seen_mem[write_address] <= write_data;
      wr_count                <= wr_count + 1;
      if (we_prev || byte_ready) strobe_viol <= strobe_viol + 1;
    end
    we_prev <= write_enable;
  end

  typedef struct {
    logic [7:0]       hdr;
    logic [3:0][31:0] w;
    int               nw;
    logic [7:0]       chk;
    logic             gap;
    logic             exp_done;
    logic             exp_err;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] fw   [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Offer one byte and return on the negedge after it was accepted; valid stays high
  task automatic send_byte(input logic [7:0] b, input logic gap);
    int n = 0;
    if (gap && $urandom_range(0, 1) == 1) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clock);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!byte_ready) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout: byte %h never accepted (byte_ready stuck 0)", b);
    end else begin
      stall += n;
      @(negedge clock);
    end
  endtask

  task automatic run_frame(input logic [7:0] hdr, input int nw, input logic [7:0] chk,
                           input logic gap);
    pulse_start();
    send_byte(hdr, 1'b0);
    stall = 0;
    for (int i = 0; i < nw; i++)
      for (int j = 0; j < 4; j++) send_byte(fw[i][8*j +: 8], gap);
    if (nw > 0) send_byte(chk, gap);
    byte_valid = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int wr0;
    reset      = 1'b1;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;

    vecs[0] = '{hdr: 8'h02, w: {32'h0, 32'h0, 32'h00300793, 32'h00000013}, nw: 2, chk: 8'hB5,
                gap: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{hdr: 8'h02, w: {32'h0, 32'h0, 32'h00300793, 32'h00000013}, nw: 2, chk: 8'hB4,
                gap: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[2] = '{hdr: 8'h02, w: {32'h0, 32'h0, 32'h00300793, 32'h00000013}, nw: 2, chk: 8'hB5,
                gap: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[3] = '{hdr: 8'h00, w: '0, nw: 0, chk: 8'h00,
                gap: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[4] = '{hdr: 8'h11, w: '0, nw: 0, chk: 8'h00,
                gap: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[5] = '{hdr: 8'h02, w: {32'h0, 32'h0, 32'h00300793, 32'h00000013}, nw: 2, chk: 8'hB5,
                gap: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
    vecs[6] = '{hdr: 8'h01, w: {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, nw: 1, chk: 8'h23,
                gap: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[7] = '{hdr: 8'h03, w: {32'h0, 32'h000000FF, 32'h22222222, 32'h11111111}, nw: 3,
                chk: 8'hFC, gap: 1'b0, exp_done: 1'b1, exp_err: 1'b0};

    // Reset values
    repeat (2) @(negedge clock);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_write_enable", 32'(write_enable), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_write_address", 32'(write_address), 32'd0);
    check("rst_write_data", write_data, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Table of complete frames
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 4; i++) fw[i] = vecs[v].w[i];
      wr0 = wr_count;
      run_frame(vecs[v].hdr, vecs[v].nw, vecs[v].chk, vecs[v].gap);
      check($sformatf("v%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
      check($sformatf("v%0d_error", v), 32'(error), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_cpu_hold", v), 32'(cpu_hold), 32'(!vecs[v].exp_done));
      check($sformatf("v%0d_writes", v), 32'(wr_count - wr0), 32'(vecs[v].nw));
      for (int i = 0; i < vecs[v].nw; i++)
        check($sformatf("v%0d_mem%0d", v, i), seen_mem[i], fw[i]);
      if (!vecs[v].gap && vecs[v].nw > 0)
        check($sformatf("v%0d_ready_drops", v), 32'(stall), 32'(vecs[v].nw));
    end

    // Start in RUN: hold rises at once, new program overwrites address 0
    check("run_cpu_hold_before", 32'(cpu_hold), 32'd0);
    pulse_start();
    check("restart_cpu_hold", 32'(cpu_hold), 32'd1);
    check("restart_byte_ready", 32'(byte_ready), 32'd1);
    wr0 = wr_count;
    send_byte(8'h01, 1'b0);
    for (int j = 0; j < 4; j++) send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    byte_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("restart_done", 32'(done), 32'd1);
    check("restart_writes", 32'(wr_count - wr0), 32'd1);
    check("restart_mem0", seen_mem[0], 32'hA5A5A5A5);
    check("restart_mem1_kept", seen_mem[1], 32'h22222222);

    // Maximum legal count fills every address
    for (int i = 0; i < 16; i++) fw[i] = {4{8'(i)}};
    wr0 = wr_count;
    run_frame(8'h10, 16, 8'h10, 1'b0);
    check("full_done", 32'(done), 32'd1);
    check("full_writes", 32'(wr_count - wr0), 32'd16);
    check("full_ready_drops", 32'(stall), 32'd16);
    for (int i = 0; i < 16; i++) check($sformatf("full_mem%0d", i), seen_mem[i], fw[i]);

    // Start during DATA is ignored
    wr0 = wr_count;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'hEF, 1'b0);
    byte_valid = 1'b0;
    pulse_start();
    send_byte(8'hBE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'h23, 1'b0);
    byte_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("mid_start_done", 32'(done), 32'd1);
    check("mid_start_writes", 32'(wr_count - wr0), 32'd1);
    check("mid_start_mem0", seen_mem[0], 32'hDEADBEEF);

    // Reset after two data bytes aborts without a write
    wr0 = wr_count;
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    byte_valid = 1'b0;
    reset      = 1'b1;
    @(negedge clock);
    check("abort_cpu_hold", 32'(cpu_hold), 32'd1);
    check("abort_byte_ready", 32'(byte_ready), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_write_address", 32'(write_address), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("abort_idle_ready", 32'(byte_ready), 32'd0);
    check("abort_writes", 32'(wr_count - wr0), 32'd0);

    check("strobe_shape", 32'(strobe_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
